// File: rtl/nuc_pkg.sv
// Shared types and helpers for the nucleotide pattern matcher.
package nuc_pkg;

  typedef enum logic [1:0] {
    A = 2'b00,
    C = 2'b01,
    G = 2'b10,
    T = 2'b11
  } nuc_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MAX_PAT = 4;

  // Mask selecting the low 2*len bits of an 8-bit window/pattern.
  function automatic logic [7:0] pat_mask(input logic [2:0] len);
    case (len)
      3'd1:    return 8'h03;
      3'd2:    return 8'h0F;
      3'd3:    return 8'h3F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/nuc_window.sv
// Four-nucleotide sliding window with a saturating fill counter.
module nuc_window
  import nuc_pkg::*;
(
  input  logic       clock,
  input  logic       reset_L,
  input  logic       clear,
  input  logic       shift,
  input  logic [1:0] din,
  output logic [7:0] window,
  output logic [2:0] fill
);

  // Fill counter tracks how many valid nucleotides sit in the window.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      fill <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (shift && (fill != 3'(MAX_PAT))) begin
      fill <= fill + 3'd1;
    end
  end

  // Window contents are qualified by fill, so they need no reset.
  always_ff @(posedge clock) begin
    if (clear) begin
      window <= '0;
    end else if (shift) begin
      window <= {window[5:0], din};
    end
  end

endmodule

// File: rtl/nuc_pattern_matcher.sv
// Scan engine: reads the nucleotide memory sequentially and counts
// (overlapping) occurrences of a 1..4 nucleotide pattern.
module nuc_pattern_matcher
  import nuc_pkg::*;
#(
  parameter int AW = 16,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          start,
  input  logic [7:0]    pattern,
  input  logic [2:0]    pat_len,
  input  logic [AW:0]   seq_len,
  output logic [AW-1:0] nuc_addr,
  output logic          nuc_re,
  input  logic [1:0]    nuc_data,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] match_count,
  output logic          found,
  output logic [AW-1:0] first_addr
);

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [7:0]    pat_q;
  logic [2:0]    plen_q;
  logic [AW:0]   slen_q;
  logic [7:0]    window;
  logic [7:0]    win_nxt;
  logic [2:0]    fill;
  logic          accept;
  logic          reject;
  logic          last;
  logic          hit;
  logic          in_scan;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  nuc_window u_window (
    .clock   (clock),
    .reset_L (reset_L),
    .clear   (accept),
    .shift   (in_scan),
    .din     (nuc_data),
    .window  (window),
    .fill    (fill)
  );

  // Memory-facing outputs decode from registered state only.
  assign in_scan  = (state == SCAN);
  assign nuc_re   = in_scan;
  assign busy     = in_scan;
  assign done     = (state == DONE);
  assign nuc_addr = in_scan ? idx : '0;

  // Parameter screening uses the live inputs, checked at the accepting edge.
  assign reject = (pat_len == 3'd0) || (pat_len > 3'(MAX_PAT)) ||
                  (seq_len == '0) || (seq_len < {{(AW-2){1'b0}}, pat_len});

  assign last    = ({1'b0, idx} == (slen_q - (AW+1)'(1)));
  assign win_nxt = {window[5:0], nuc_data};
  assign hit     = in_scan &&
                   (({1'b0, fill} + 4'd1) >= {1'b0, plen_q}) &&
                   (((win_nxt ^ pat_q) & pat_mask(plen_q)) == 8'h00);

  // State register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is honoured only in IDLE and DONE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = reject ? DONE : SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latched operands are only consumed after an accepted start.
  always_ff @(posedge clock) begin
    if (accept) begin
      pat_q  <= pattern;
      plen_q <= pat_len;
      slen_q <= seq_len;
    end
  end

  // Read index advances once per SCAN cycle and stops on the last address.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      idx <= '0;
    end else if (accept) begin
      idx <= '0;
    end else if (in_scan && !last) begin
      idx <= idx + AW'(1);
    end
  end

  // Result registers: cleared on accept, updated on each match.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      match_count <= '0;
      found       <= 1'b0;
      first_addr  <= '0;
    end else if (accept) begin
      match_count <= '0;
      found       <= 1'b0;
      first_addr  <= '0;
    end else if (hit) begin
      match_count <= sat_inc(match_count);
      if (!found) begin
        found      <= 1'b1;
        first_addr <= idx - AW'(plen_q) + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_nuc_pattern_matcher.sv
// Directed bench for nuc_pattern_matcher with a small nucleotide memory model.
module tb_nuc_pattern_matcher;

  localparam int AW = 16;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset_L;
  logic          start;
  logic [7:0]    pattern;
  logic [2:0]    pat_len;
  logic [AW:0]   seq_len;
  logic [AW-1:0] nuc_addr;
  logic          nuc_re;
  logic [1:0]    nuc_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] match_count;
  logic          found;
  logic [AW-1:0] first_addr;

  logic [AW-1:0] sat_addr;
  logic          sat_re;
  logic [1:0]    sat_data;
  logic          sat_busy;
  logic          sat_done;
  logic [1:0]    sat_count;
  logic          sat_found;
  logic [AW-1:0] sat_first;

  logic [1:0] mem [0:15];

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      seq;
    int         slen;
    logic [7:0] pat;
    logic [2:0] plen;
    int         exp_cnt;
    logic       exp_found;
    int         exp_first;
    int         exp_done;
    int         poke;
    int         exp_sat;
  } vec_t;

  vec_t vq[$];

  always #5 clock = ~clock;

  assign nuc_data = mem[nuc_addr[3:0]];
  assign sat_data = mem[sat_addr[3:0]];

  nuc_pattern_matcher #(.AW(AW), .CW(CW)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .start       (start),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .seq_len     (seq_len),
    .nuc_addr    (nuc_addr),
    .nuc_re      (nuc_re),
    .nuc_data    (nuc_data),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .found       (found),
    .first_addr  (first_addr)
  );

  nuc_pattern_matcher #(.AW(AW), .CW(2)) dut_sat (
    .clock       (clock),
    .reset_L     (reset_L),
    .start       (start),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .seq_len     (seq_len),
    .nuc_addr    (sat_addr),
    .nuc_re      (sat_re),
    .nuc_data    (sat_data),
    .busy        (sat_busy),
    .done        (sat_done),
    .match_count (sat_count),
    .found       (sat_found),
    .first_addr  (sat_first)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string seq, input int slen, input logic [7:0] pat,
                              input logic [2:0] plen, input int cnt, input logic fnd,
                              input int first, input int dcyc, input int poke, input int sat);
    vec_t v;
    v.seq = seq; v.slen = slen; v.pat = pat; v.plen = plen;
    v.exp_cnt = cnt; v.exp_found = fnd; v.exp_first = first;
    v.exp_done = dcyc; v.poke = poke; v.exp_sat = sat;
    return v;
  endfunction

  task automatic load(input string seq);
    byte ch;
    for (int i = 0; i < 16; i++) mem[i] = 2'b00;
    for (int i = 0; i < seq.len(); i++) begin
      ch = seq[i];
      case (ch)
        "A":     mem[i] = 2'b00;
        "C":     mem[i] = 2'b01;
        "G":     mem[i] = 2'b10;
        default: mem[i] = 2'b11;
      endcase
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   cyc;
    int   reads;
    int   done_cyc;
    logic addr_ok;
    load(v.seq);
    @(negedge clock);
    pattern = v.pat;
    pat_len = v.plen;
    seq_len = 17'(v.slen);
    start   = 1'b1;
    @(negedge clock);
    // Scramble the operands: the scan must use the latched copies.
    start    = 1'b0;
    pattern  = ~v.pat;
    pat_len  = 3'd1;
    seq_len  = 17'd1;
    cyc      = 1;
    reads    = 0;
    done_cyc = 0;
    addr_ok  = 1'b1;
    while (cyc <= v.slen + 4 && done_cyc == 0) begin
      if (nuc_re === 1'b1) begin
        if (nuc_addr !== 16'(reads)) addr_ok = 1'b0;
        reads++;
      end
      if (busy !== nuc_re) addr_ok = 1'b0;
      if (done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        start = (cyc == v.poke);
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, " done_cycle"}, done_cyc, v.exp_done);
    check({tag, " reads"}, reads, (v.exp_done == 1) ? 0 : v.slen);
    check({tag, " addr_order"}, {31'd0, addr_ok}, 32'd1);
    check({tag, " match_count"}, {16'd0, match_count}, v.exp_cnt);
    check({tag, " found"}, {31'd0, found}, {31'd0, v.exp_found});
    check({tag, " first_addr"}, {16'd0, first_addr}, v.exp_first);
    if (v.exp_sat >= 0) begin
      check({tag, " sat_count"}, {30'd0, sat_count}, v.exp_sat);
      check({tag, " sat_found"}, {31'd0, sat_found}, 32'd1);
    end
    @(negedge clock);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic saw_done;
    reset_L = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    pat_len = 3'd0;
    seq_len = '0;
    load("");
    repeat (2) @(negedge clock);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset nuc_re", {31'd0, nuc_re}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset nuc_addr", {16'd0, nuc_addr}, 32'd0);
    check("reset match_count", {16'd0, match_count}, 32'd0);
    check("reset found", {31'd0, found}, 32'd0);
    check("reset first_addr", {16'd0, first_addr}, 32'd0);
    reset_L = 1'b1;

    //            seq            len pat    plen cnt fnd  first done poke sat
    vq.push_back(mk("ACGTACGT",     8, 8'h06, 3'd3, 2, 1'b1, 0,  9, -1, -1));
    vq.push_back(mk("AAAAA",        5, 8'h00, 3'd2, 4, 1'b1, 0,  6, -1, -1));
    vq.push_back(mk("ACGT",         4, 8'h1B, 3'd0, 0, 1'b0, 0,  1, -1, -1));
    vq.push_back(mk("AC",           2, 8'h06, 3'd3, 0, 1'b0, 0,  1, -1, -1));
    vq.push_back(mk("GGGGT",        5, 8'h03, 3'd1, 1, 1'b1, 4,  6,  2, -1));
    vq.push_back(mk("CCCCC",        5, 8'h01, 3'd1, 5, 1'b1, 0,  6, -1,  3));
    vq.push_back(mk("GATTACAGATT", 11, 8'h8F, 3'd4, 2, 1'b1, 0, 12, -1, -1));
    vq.push_back(mk("ACGTG",        5, 8'hFE, 3'd1, 2, 1'b1, 2,  6, -1, -1));
    vq.push_back(mk("ACGT",         4, 8'h06, 3'd5, 0, 1'b0, 0,  1, -1, -1));
    vq.push_back(mk("TGCA",         4, 8'hE4, 3'd4, 1, 1'b1, 0,  5, -1, -1));
    vq.push_back(mk("AAAA",         4, 8'h03, 3'd1, 0, 1'b0, 0,  5, -1, -1));
    vq.push_back(mk("",             0, 8'h00, 3'd1, 0, 1'b0, 0,  1, -1, -1));
    vq.push_back(mk("ACACACA",      7, 8'h04, 3'd3, 3, 1'b1, 0,  8, -1, -1));

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(vq[i], $sformatf("vec%0d", i));
    end

    // Abort an 8-nucleotide scan with reset in cycle 3.
    load("ACGTACGT");
    @(negedge clock);
    pattern = 8'h06;
    pat_len = 3'd3;
    seq_len = 17'd8;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort pre busy", {31'd0, busy}, 32'd1);
    check("abort pre addr", {16'd0, nuc_addr}, 32'd2);
    reset_L = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort nuc_re", {31'd0, nuc_re}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort nuc_addr", {16'd0, nuc_addr}, 32'd0);
    check("abort match_count", {16'd0, match_count}, 32'd0);
    check("abort found", {31'd0, found}, 32'd0);
    check("abort first_addr", {16'd0, first_addr}, 32'd0);
    @(negedge clock);
    reset_L  = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check("abort no_done", {31'd0, saw_done}, 32'd0);
    run_vec(vq[0], "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
